// File: rtl/branch_predictor_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_unit
// Purpose  : Direct-mapped branch target buffer with 2-bit saturating
//            counters. Zero-latency lookup for fetch, update from execute,
//            mispredict detection and saturating resolution statistics.
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor_unit #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc_i,
  output logic        predict_taken_o,
  output logic [31:0] predict_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic        upd_is_jump_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  input  logic        clear_i,
  output logic        mispredict_o,
  output logic [31:0] branch_count_o,
  output logic [31:0] mispredict_count_o
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // Table storage
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Lookup side decode
  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic                  w_lk_hit;

  // Update side decode
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_BITS-1:0]   w_up_tag;
  logic                  w_up_hit;
  logic                  w_wr_ctr;
  logic                  w_wr_tgt;
  logic                  w_alloc;
  logic [1:0]            w_ctr_d;

  // Byte-offset bits of instruction PCs carry no information here
  logic w_unused;
  assign w_unused = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign w_lk_idx = lookup_pc_i[INDEX_BITS+1:2];
  assign w_lk_tag = lookup_pc_i[31:INDEX_BITS+2];
  assign w_up_idx = upd_pc_i[INDEX_BITS+1:2];
  assign w_up_tag = upd_pc_i[31:INDEX_BITS+2];

  // Combinational lookup; reads pre-update contents (no write bypass)
  always_comb begin
    w_lk_hit        = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    predict_taken_o = w_lk_hit && ctr_q[w_lk_idx][1];
    predict_target_o = predict_taken_o ? target_q[w_lk_idx] : (lookup_pc_i + 32'd4);
  end

  // Decide which entry fields the resolved branch rewrites
  always_comb begin
    w_up_hit = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);
    w_wr_ctr = 1'b0;
    w_wr_tgt = 1'b0;
    w_alloc  = 1'b0;
    w_ctr_d  = ctr_q[w_up_idx];
    if (upd_valid_i) begin
      if (w_up_hit) begin
        w_wr_ctr = 1'b1;
        if (upd_is_jump_i) begin
          w_ctr_d  = 2'b11;
          w_wr_tgt = 1'b1;
        end else if (upd_taken_i) begin
          w_ctr_d  = (ctr_q[w_up_idx] == 2'b11) ? 2'b11 : ctr_q[w_up_idx] + 2'd1;
          w_wr_tgt = 1'b1;
        end else begin
          w_ctr_d  = (ctr_q[w_up_idx] == 2'b00) ? 2'b00 : ctr_q[w_up_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        // Miss on a taken branch/jump allocates, evicting any alias
        w_alloc  = 1'b1;
        w_wr_ctr = 1'b1;
        w_wr_tgt = 1'b1;
        w_ctr_d  = upd_is_jump_i ? 2'b11 : 2'b10;
      end
    end
  end

  // Table state: reset, bulk clear (dominates updates), or single-entry write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      if (w_wr_ctr) ctr_q[w_up_idx]    <= w_ctr_d;
      if (w_wr_tgt) target_q[w_up_idx] <= upd_target_i;
      if (w_alloc) begin
        valid_q[w_up_idx] <= 1'b1;
        tag_q[w_up_idx]   <= w_up_tag;
      end
    end
  end

  // Mispredict: direction wrong, or both taken with a wrong target
  always_comb begin
    mispredict_o = upd_valid_i &&
                   ((upd_pred_taken_i != upd_taken_i) ||
                    (upd_taken_i && upd_pred_taken_i && (upd_pred_target_i != upd_target_i)));
  end

  // Saturating statistics next-state; independent of clear_i
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid_i && (branch_cnt_q != 32'hFFFF_FFFF))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict_o && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_unit
// Purpose  : Scoreboard bench for branch_predictor_unit: directed scenarios
//            plus randomized traffic against a behavioural BTB model.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor_unit;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc_i;
  logic        predict_taken_o;
  logic [31:0] predict_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_is_jump_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        clear_i;
  logic        mispredict_o;
  logic [31:0] branch_count_o;
  logic [31:0] mispredict_count_o;

  branch_predictor_unit dut (
    .clk                (clk),
    .rst                (rst),
    .lookup_pc_i        (lookup_pc_i),
    .predict_taken_o    (predict_taken_o),
    .predict_target_o   (predict_target_o),
    .upd_valid_i        (upd_valid_i),
    .upd_pc_i           (upd_pc_i),
    .upd_taken_i        (upd_taken_i),
    .upd_is_jump_i      (upd_is_jump_i),
    .upd_target_i       (upd_target_i),
    .upd_pred_taken_i   (upd_pred_taken_i),
    .upd_pred_target_i  (upd_pred_target_i),
    .clear_i            (clear_i),
    .mispredict_o       (mispredict_o),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: 64 entries indexed by word address mod 64
  bit          m_valid [64];
  longint      m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  longint      m_bc, m_mc;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic longint tag_of(input logic [31:0] pc);
    return longint'(pc / 256);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
    int i;
    i  = idx_of(pc);
    pt = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    tgt = pt ? m_tgt[i] : pc + 32'd4;
  endtask

  // One clock of stimulus: expectation pushed, model advanced, then edge
  task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic uj, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt, input logic clr);
    exp_t e;
    int   i;
    bit   hit, mp;
    lookup_pc_i = lpc; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
    upd_is_jump_i = uj; upd_target_i = utgt; upd_pred_taken_i = upt;
    upd_pred_target_i = uptgt; clear_i = clr;

    model_predict(lpc, e.pt, e.tgt);
    mp   = uv && ((upt != ut) || (ut && upt && (uptgt != utgt)));
    e.mp = mp;
    e.bc = m_bc[31:0];
    e.mc = m_mc[31:0];
    exp_q.push_back(e);

    if (uv && m_bc < 64'hFFFF_FFFF) m_bc++;
    if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
    if (clr) begin
      for (int k = 0; k < 64; k++) begin m_valid[k] = 0; m_ctr[k] = 1; end
    end else if (uv) begin
      i   = idx_of(upc);
      hit = m_valid[i] && (m_tag[i] == tag_of(upc));
      if (hit && uj) begin
        m_ctr[i] = 3; m_tgt[i] = utgt;
      end else if (hit && ut) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = utgt;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt;
        m_ctr[i] = uj ? 3 : 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] lpc);
    drive(lpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] lpc, input logic [31:0] upc, input logic ut,
                     input logic uj, input logic [31:0] utgt, input logic upt,
                     input logic [31:0] uptgt);
    drive(lpc, 1'b1, upc, ut, uj, utgt, upt, uptgt, 1'b0);
  endtask

  // Monitor: outputs are combinational, compared mid-cycle on falling edge
  always @(negedge clk) begin
    if (rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (predict_taken_o !== e.pt) begin
        errors++;
        $display("FAIL predict_taken pc=%h got=%b exp=%b", lookup_pc_i, predict_taken_o, e.pt);
      end
      checks++;
      if (predict_target_o !== e.tgt) begin
        errors++;
        $display("FAIL predict_target pc=%h got=%h exp=%h", lookup_pc_i, predict_target_o, e.tgt);
      end
      checks++;
      if (mispredict_o !== e.mp) begin
        errors++;
        $display("FAIL mispredict upc=%h got=%b exp=%b", upd_pc_i, mispredict_o, e.mp);
      end
      checks++;
      if (branch_count_o !== e.bc) begin
        errors++;
        $display("FAIL branch_count got=%0d exp=%0d", branch_count_o, e.bc);
      end
      checks++;
      if (mispredict_count_o !== e.mc) begin
        errors++;
        $display("FAIL mispredict_count got=%0d exp=%0d", mispredict_count_o, e.mc);
      end
    end
  end

  initial begin
    logic [31:0] pcs [8];
    logic [31:0] upc, lpc, tgt, ptgt;
    logic        pt, ut, uj, upt;

    rst = 1'b0;
    lookup_pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
    upd_is_jump_i = 1'b0; upd_target_i = '0; upd_pred_taken_i = 1'b0;
    upd_pred_target_i = '0; clear_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    look(32'h100);
    // Cold taken branch: mispredict, allocate at ctr=10
    upd(32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104);
    look(32'h100);
    // Hysteresis; first update also shows same-cycle pre-update lookup
    upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    look(32'h100);
    upd(32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104);
    upd(32'h100, 32'h100, 1'b1, 1'b0, 32'h80, 1'b1, 32'h80);
    upd(32'h100, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    look(32'h100);
    // Alias at same index, different tag
    look(32'h200);
    upd(32'h200, 32'h200, 1'b1, 1'b0, 32'h40, 1'b0, 32'h204);
    look(32'h100);
    look(32'h200);
    // Wrong target while direction correct
    upd(32'h200, 32'h200, 1'b1, 1'b0, 32'h48, 1'b1, 32'h40);
    look(32'h200);
    // Clear dominates a same-cycle taken update
    drive(32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 32'h60, 1'b0, 32'h304, 1'b1);
    look(32'h100);
    look(32'h300);
    look(32'h200);
    // Jump at top of address space and lookup wrap
    look(32'hFFFF_FFFC);
    upd(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
    look(32'hFFFF_FFFC);
    look(32'hFFFF_FFF8);

    // Randomized traffic over a small PC pool to force hits and aliases
    for (int k = 0; k < 8; k++)
      pcs[k] = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2);
    pcs[7] = 32'hFFFF_FFFC;
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        // Asynchronous reset mid-cycle with an update in flight
        upd_valid_i = 1'b1; upd_taken_i = 1'b1; upd_pc_i = pcs[0];
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
      end
      lpc = pcs[$urandom_range(0, 7)];
      upc = pcs[$urandom_range(0, 7)];
      uj  = ($urandom_range(0, 7) == 0);
      ut  = uj ? 1'b1 : $urandom_range(0, 1) == 1;
      tgt = $urandom_range(0, 15) << 4;
      model_predict(upc, pt, ptgt);
      if ($urandom_range(0, 3) == 0) begin
        upt  = $urandom_range(0, 1) == 1;
        ptgt = $urandom_range(0, 15) << 4;
      end else begin
        upt = pt;
      end
      drive(lpc, $urandom_range(0, 3) != 0, upc, ut, uj, tgt, upt, ptgt,
            $urandom_range(0, 49) == 0);
    end

    upd_valid_i = 1'b0; clear_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
Direct-mapped branch target buffer with 2-bit saturating counters. Answers the fetch stage's per-cycle prediction request for the current PC. Accepts branch/jump resolution from the execute stage one or more cycles later. Flags mispredictions and keeps resolution and mispredict statistics.

Parameters:
INDEX_BITS, 6, log2 of entry count (64 entries); index = pc[INDEX_BITS+1:2]
TAG_BITS, 30-INDEX_BITS, tag = pc[31:INDEX_BITS+2]

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
lookup_pc_i  input  32  fetch PC (PCF)
predict_taken_o  output  1  predicted taken for lookup_pc_i
predict_target_o  output  32  predicted next PC
upd_valid_i  input  1  branch/jump resolved in execute this cycle
upd_pc_i  input  32  PC of resolved instruction (PCE)
upd_taken_i  input  1  actual outcome (1 for jumps)
upd_is_jump_i  input  1  unconditional jal/jalr
upd_target_i  input  32  actual target (PCTargetE)
upd_pred_taken_i  input  1  prediction carried down the pipe with the instruction
upd_pred_target_i  input  32  predicted target carried down the pipe
clear_i  input  1  synchronous invalidate of all entries
mispredict_o  output  1  resolution disagrees with prediction (combinational)
branch_count_o  output  32  resolved branch/jump count
mispredict_count_o  output  32  mispredict count

Behaviour:
- Entry fields: valid, tag[TAG_BITS], target[32], ctr[2].
- rst low, asynchronous: all valid=0; all ctr=2'b01; both counts=0.
- Outputs are combinational from the registers once reset releases.
- Lookup (combinational, zero latency):
  - hit = valid[idx] and tag[idx]==lookup tag.
  - predict_taken_o = hit and ctr[1].
  - predict_target_o = target[idx] if predict_taken_o, else lookup_pc_i+4 (32-bit wrap: 0xFFFFFFFC+4 = 0x00000000).
- Update (at posedge when upd_valid_i=1 and clear_i=0), on index/tag of upd_pc_i:
  - Hit, conditional branch: ctr increments saturating at 2'b11 if taken, decrements saturating at 2'b00 if not taken. If taken, target := upd_target_i.
  - Hit, jump: ctr := 2'b11; target := upd_target_i.
  - Miss and taken: allocate/replace the entry. valid=1, tag written, target=upd_target_i, ctr = 2'b11 for a jump, 2'b10 for a branch.
  - Miss and not taken: no table change.
- mispredict_o = upd_valid_i and ((upd_pred_taken_i != upd_taken_i) or (upd_taken_i and upd_pred_taken_i and upd_pred_target_i != upd_target_i)). It is 0 when upd_valid_i=0.
- Statistics:
  - branch_count_o increments on each upd_valid_i cycle.
  - mispredict_count_o increments when mispredict_o=1.
  - Both saturate at 0xFFFFFFFF and are not affected by clear_i.
- clear_i:
  - At posedge, all valid:=0 and all ctr:=2'b01.
  - Takes priority over a same-cycle update; the table write is dropped, but statistics still count.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no bypass; the new value is visible the next cycle.
- Lookup and update are independent ports; any index combination is legal.
- Reset asserted mid-operation clears state immediately; no partial update survives.

Test Plan:
- Reset: hold rst=0, then release. Lookup at 0x00000100 -> predict_taken_o=0, predict_target_o=0x00000104, both counts 0.
- Cold taken branch: update pc=0x100, taken=1, target=0x80, pred_taken=0. -> mispredict_o=1 that cycle; next cycle lookup 0x100 gives taken=1, target=0x80; mispredict_count=1, branch_count=1.
- Hysteresis: entry at ctr=2'b10, apply one not-taken update -> ctr=01, lookup not taken. Apply two taken updates -> ctr=11. Apply one not-taken -> ctr=10, lookup still taken.
- Alias: with INDEX_BITS=6, entry allocated at 0x100; lookup 0x200 (same index, different tag) -> predict_taken_o=0, target 0x204. Taken update at 0x200 -> replaces the entry; lookup 0x100 now misses.
- Same-cycle: lookup 0x100 while updating 0x100 not-taken from ctr=10 -> that cycle predict_taken_o=1, next cycle 0.
- Clear priority: clear_i=1 with a taken update at 0x300 -> next cycle lookups of 0x100 and 0x300 both miss; branch_count increments.
